// File: rtl/demux_4_stream_pkg.sv
// Shared definitions for the 4-channel stream demultiplexer: channel count,
// per-channel FIFO depth, index/count types and a select decode helper.
package demux_4_stream_pkg;

    localparam int NUM_CH   = 4;
    localparam int CH_DEPTH = 2;

    typedef logic [1:0] ch_idx_t;
    typedef logic [1:0] cnt_t;

    // One-hot decode of a destination channel index.
    function automatic logic [NUM_CH-1:0] ch_onehot(input ch_idx_t sel);
        logic [NUM_CH-1:0] oh;
        oh      = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/demux_slot_fifo.sv
// Two-entry FIFO used as one consumer channel of demux_4_stream.
// Storage is not reset; only count and pointers are. The head entry is a
// combinational read of registered storage.
module demux_slot_fifo
    import demux_4_stream_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem_q [CH_DEPTH];
    logic             wp_q, wp_d;
    logic             rp_q, rp_d;
    cnt_t             count_q, count_d;
    logic             wr_en;
    logic             rd_en;

    // Qualify requests locally so the FIFO can never over- or underflow.
    always_comb begin
        full    = (count_q == cnt_t'(CH_DEPTH));
        empty   = (count_q == '0);
        wr_en   = push && !full;
        rd_en   = pop && !empty;
        wp_d    = wp_q ^ wr_en;
        rp_d    = rp_q ^ rd_en;
        count_d = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
        endcase
        head    = mem_q[rp_q];
    end

    // Count and pointers: cleared asynchronously, pending words discarded.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            wp_q    <= 1'b0;
            rp_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
        end
    end

    // Data storage: written at the write pointer, deliberately not reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wp_q] <= wdata;
        end
    end

endmodule

// File: rtl/demux_4_stream.sv
// demux_4_stream: steers one tagged producer stream into four consumer
// channels, each buffered by a 2-entry FIFO so a stalled consumer only
// blocks words addressed to it.
// Optional build macro DEMUX4_STREAM_BYPASS_EN: a word addressed to an empty
// channel whose consumer is ready passes straight through in the same cycle
// without being written to the FIFO.
//
// Handshake: a word moves on a rising edge when valid && ready are both high
// on that interface; the sender holds data/select stable while valid is high
// and ready is low. in_ready depends only on registered channel counts and
// in_select, never on out_ready.
module demux_4_stream
    import demux_4_stream_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_select,
    input  logic [WIDTH-1:0] in_data,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3
);

    logic [NUM_CH-1:0] sel_oh;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] wr;
    logic [NUM_CH-1:0] rd;
    logic              accept;
    logic [WIDTH-1:0]  head    [NUM_CH];
    logic [WIDTH-1:0]  data_mx [NUM_CH];

`ifdef DEMUX4_STREAM_BYPASS_EN
    logic [NUM_CH-1:0] bypass;

    // Pass-through is taken when the addressed channel is empty and its consumer is ready.
    always_comb bypass = sel_oh & empty & out_ready;
`else
    localparam logic [NUM_CH-1:0] bypass = '0;
`endif

    // Select decode, ready mux and per-channel push/pop/output steering.
    always_comb begin
        sel_oh   = ch_onehot(ch_idx_t'(in_select));
        in_ready = !full[in_select];
        accept   = in_valid && in_ready;
        for (int k = 0; k < NUM_CH; k++) begin
            wr[k]        = accept && sel_oh[k] && !bypass[k];
            rd[k]        = !empty[k] && out_ready[k];
            out_valid[k] = !empty[k] || (bypass[k] && in_valid);
            data_mx[k]   = bypass[k] ? in_data : head[k];
        end
    end

    always_comb begin
        out_data0 = data_mx[0];
        out_data1 = data_mx[1];
        out_data2 = data_mx[2];
        out_data3 = data_mx[3];
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        demux_slot_fifo #(
            .WIDTH (WIDTH)
        ) u_fifo (
            .clock   (clock),
            .reset_n (reset_n),
            .push    (wr[g]),
            .pop     (rd[g]),
            .wdata   (in_data),
            .full    (full[g]),
            .empty   (empty[g]),
            .head    (head[g])
        );
    end

endmodule

// File: tb/tb_demux_4_stream.sv
// Bench for demux_4_stream: a per-cycle vector table for ready/valid
// behaviour, per-channel expected-data queues for word content and order,
// and hand-written sequences for asynchronous reset and pass-through latency.
module tb_demux_4_stream;

    localparam int WIDTH = 32;

    logic             clock;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_select;
    logic [WIDTH-1:0] in_data;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [WIDTH-1:0] out_data0, out_data1, out_data2, out_data3;
    logic [WIDTH-1:0] od [4];

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] exp_q [4][$];

    typedef struct {
        logic             v;
        logic [1:0]       sel;
        logic [WIDTH-1:0] data;
        logic [3:0]       ordy;
        logic             exp_rdy;
        logic [3:0]       exp_ov;
    } vec_t;

    vec_t vecs [18];

    demux_4_stream #(.WIDTH(WIDTH)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_select (in_select),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .out_data3 (out_data3)
    );

    assign od[0] = out_data0;
    assign od[1] = out_data1;
    assign od[2] = out_data2;
    assign od[3] = out_data3;

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] sel, input logic [WIDTH-1:0] d, input logic [3:0] ordy);
        in_valid  = v;
        in_select = sel;
        in_data   = d;
        out_ready = ordy;
    endtask

    // scoreboard: handshakes sampled mid-cycle, pushes recorded before pops
    always @(negedge clock) begin
        if (reset_n) begin
            if (in_valid && in_ready) exp_q[in_select].push_back(in_data);
            for (int k = 0; k < 4; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    if (exp_q[k].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL pop_ch%0d: got %0h expected no word", k, od[k]);
                    end else begin
                        check($sformatf("pop_ch%0d", k), od[k], exp_q[k].pop_front());
                    end
                end
            end
        end
    end

    initial begin
        vecs[0]  = '{1'b1, 2'd2, 32'hA5A5_0001, 4'b0000, 1'b1, 4'b0000};
        vecs[1]  = '{1'b0, 2'd2, 32'h0,         4'b0000, 1'b1, 4'b0100};
        vecs[2]  = '{1'b1, 2'd1, 32'h11,        4'b0000, 1'b1, 4'b0100};
        vecs[3]  = '{1'b1, 2'd1, 32'h22,        4'b0000, 1'b1, 4'b0110};
        vecs[4]  = '{1'b1, 2'd1, 32'h33,        4'b0000, 1'b0, 4'b0110};
        vecs[5]  = '{1'b1, 2'd1, 32'h33,        4'b0010, 1'b0, 4'b0110};
        vecs[6]  = '{1'b1, 2'd1, 32'h33,        4'b0010, 1'b1, 4'b0110};
        vecs[7]  = '{1'b0, 2'd1, 32'h0,         4'b0010, 1'b1, 4'b0110};
        vecs[8]  = '{1'b1, 2'd0, 32'hC0,        4'b0000, 1'b1, 4'b0100};
        vecs[9]  = '{1'b1, 2'd0, 32'hC1,        4'b0000, 1'b1, 4'b0101};
        vecs[10] = '{1'b0, 2'd0, 32'h0,         4'b0000, 1'b0, 4'b0101};
        vecs[11] = '{1'b1, 2'd3, 32'hBEEF,      4'b0000, 1'b1, 4'b0101};
        vecs[12] = '{1'b0, 2'd3, 32'h0,         4'b0000, 1'b1, 4'b1101};
        vecs[13] = '{1'b1, 2'd2, 32'h6,         4'b0100, 1'b1, 4'b1101};
        vecs[14] = '{1'b0, 2'd2, 32'h0,         4'b0000, 1'b1, 4'b1101};
        vecs[15] = '{1'b0, 2'd0, 32'h0,         4'b1111, 1'b0, 4'b1101};
        vecs[16] = '{1'b0, 2'd0, 32'h0,         4'b1111, 1'b1, 4'b0001};
        vecs[17] = '{1'b0, 2'd0, 32'h0,         4'b0000, 1'b1, 4'b0000};

        reset_n = 1'b0;
        drive(1'b0, 2'd0, '0, 4'b0000);
        step();
        step();
        check("reset_out_valid", 32'(out_valid), 32'h0);
        check("reset_in_ready", 32'(in_ready), 32'h1);
        reset_n = 1'b1;

        // table: inputs applied, ready/valid checked before the edge
        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].v, vecs[i].sel, vecs[i].data, vecs[i].ordy);
            #1;
            check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
            check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
            if (i == 1) check("vec1_out_data2", out_data2, 32'hA5A5_0001);
            step();
        end
        for (int k = 0; k < 4; k++) check($sformatf("drain_ch%0d_left", k), 32'(exp_q[k].size()), 32'h0);

        // asynchronous reset with channels 0 and 3 full
        drive(1'b1, 2'd0, 32'h100, 4'b0000); step();
        drive(1'b1, 2'd0, 32'h101, 4'b0000); step();
        drive(1'b1, 2'd3, 32'h300, 4'b0000); step();
        drive(1'b1, 2'd3, 32'h301, 4'b0000); step();
        drive(1'b0, 2'd0, '0, 4'b0000);
        #1;
        check("pre_rst_out_valid", 32'(out_valid), 32'h9);
        check("pre_rst_in_ready", 32'(in_ready), 32'h0);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'h0);
        check("mid_rst_in_ready", 32'(in_ready), 32'h1);
        for (int k = 0; k < 4; k++) exp_q[k].delete();
        step();
        step();
        reset_n = 1'b1;
        in_select = 2'd3;
        #1;
        check("post_rst_out_valid", 32'(out_valid), 32'h0);
        check("post_rst_in_ready_ch3", 32'(in_ready), 32'h1);
        drive(1'b1, 2'd0, 32'hD00D, 4'b0000); step();
        drive(1'b0, 2'd0, '0, 4'b0001);
        #1;
        check("post_rst_push_valid", 32'(out_valid), 32'h1);
        step();
        drive(1'b0, 2'd0, '0, 4'b0000);

        // pass-through latency on an empty, ready channel
        step();
        drive(1'b1, 2'd1, 32'h77, 4'b0010);
        #1;
`ifdef DEMUX4_STREAM_BYPASS_EN
        check("byp_same_cycle_valid", 32'(out_valid), 32'h2);
        check("byp_same_cycle_data", out_data1, 32'h77);
        step();
        drive(1'b0, 2'd1, '0, 4'b0000);
        #1;
        check("byp_fifo_unwritten", 32'(out_valid), 32'h0);
`else
        check("lat_same_cycle_valid", 32'(out_valid), 32'h0);
        step();
        drive(1'b0, 2'd1, '0, 4'b0010);
        #1;
        check("lat_next_cycle_valid", 32'(out_valid), 32'h2);
        check("lat_next_cycle_data", out_data1, 32'h77);
        step();
        drive(1'b0, 2'd1, '0, 4'b0000);
        #1;
        check("lat_drained", 32'(out_valid), 32'h0);
`endif
        step();
        for (int k = 0; k < 4; k++) check($sformatf("final_ch%0d_left", k), 32'(exp_q[k].size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_4_stream.md
Name: demux_4_stream

Overview:
- Inverse of the 4:1 result select: takes one WIDTH-bit producer stream tagged with a 2-bit destination and steers each word to one of four consumer channels.
- Each channel has a 2-entry FIFO, so a stalled consumer only blocks traffic addressed to it.
- Sits between the ALU result bus and the four writeback/forwarding consumers of the CPU datapath.

Parameters:
- WIDTH, 32, data word width in bits.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer word valid.
- in_ready  output  1  block accepts the word this cycle.
- in_select  input  2  destination channel 0..3.
- in_data  input  WIDTH  producer word.
- out_valid  output  4  bit k: channel k holds a word.
- out_ready  input  4  bit k: consumer k takes the word this cycle.
- out_data0, out_data1, out_data2, out_data3  output  WIDTH each  head word of channel k.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Handshakes:
  - Input transfer ("push") happens on a rising edge with in_valid && in_ready.
  - Output transfer ("pop" of channel k) happens on a rising edge with out_valid[k] && out_ready[k].
- Per channel k: 2-entry FIFO with count_k in 0..2, 1-bit write pointer wp_k and 1-bit read pointer rp_k. Pointers wrap 1 -> 0.
- in_ready = (count[in_select] != 2).
  - Depends only on registered count and in_select, never on out_ready; there is no combinational ready path.
  - in_ready is a function of in_select even when in_valid = 0.
- Push to channel k: write in_data to entry wp_k, wp_k++, count_k++.
- Pop of channel k: rp_k++, count_k--.
- Simultaneous push and pop on the same channel:
  - Legal only when count_k is 1 or 2; a push is refused when count_k = 2.
  - count_k is unchanged; both pointers advance.
- out_valid[k] = (count_k != 0). out_data_k = entry[rp_k] (registered storage, combinational read).
- Latency: a word pushed at edge N is visible on out_data_k and out_valid[k] after edge N (1 cycle).
- Per-channel ordering is preserved. Words for different channels are independent.
- Holding rules:
  - The producer must hold in_data and in_select stable while in_valid && !in_ready.
  - The block holds out_data_k stable while out_valid[k] && !out_ready[k].
- Reset (asserted at any time, including mid-transfer):
  - All count = 0, pointers = 0, out_valid = 4'b0000.
  - Any pending words are discarded.
  - in_ready reads 1 during reset.
  - out_data values are don't-care; storage is not reset.
- Deassertion of reset_n is assumed synchronised externally. The first push is allowed on the first edge after release.

Optional Feature:
- DEMUX4_STREAM_BYPASS_EN defined:
  - When count[in_select] = 0 and out_ready[in_select] = 1, an input word passes straight through combinationally.
  - In that case: out_valid[sel] = in_valid, out_data_sel = in_data, and the FIFO is not written.
  - Latency is 0 in this case. in_ready stays as specified above.
- Not defined: no bypass; latency is always 1 cycle; out_valid and out_data are purely registered-storage driven.

Decomposition:
- Shared package demux_4_stream_pkg:
  - NUM_CH = 4, CH_DEPTH = 2.
  - Channel-index type (2-bit) and count type (2-bit).
- Sub-module demux_slot_fifo #(WIDTH): the 2-entry FIFO with push, pop, full, empty and head.
  - Instantiated four times in the top-level demux_4_stream.
  - Top level holds only the select decode and the in_ready mux.

Test Plan:
- Reset, then push 0xA5A5_0001 to channel 2 with all out_ready = 0 → after 1 edge: out_valid = 4'b0100, out_data2 = 0xA5A5_0001; out_data0/1/3 not valid.
- Push 0x11, 0x22, 0x33 to channel 1 with out_ready[1] = 0 → first two accepted; in_ready = 0 for the third. Then raise out_ready[1] → pops 0x11 then 0x22; 0x33 accepted the cycle after the first pop; order preserved.
- Channel 0 full and stalled; push 0xBEEF to channel 3 → in_ready = 1, accepted; out_data3 = 0xBEEF next cycle; channel 0 contents unchanged.
- Channel 2 at count 1 (0x5), simultaneous push 0x6 with out_ready[2] = 1 → 0x5 consumed, count stays 1, out_data2 = 0x6 next cycle.
- Fill channels 0 and 3 with two words each, assert reset_n = 0 asynchronously mid-cycle → out_valid = 0 immediately (before the next edge), in_ready = 1; after release, channels are empty.
- Bypass (DEMUX4_STREAM_BYPASS_EN defined): channel 1 empty, out_ready[1] = 1, push 0x77 → out_valid[1] = 1 and out_data1 = 0x77 in the same cycle; count_1 stays 0. Without the macro → 0x77 appears one cycle later.
